// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant sequencer.
// The optional RR_TIMEOUT_EN build adds forced grant release.
package rr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // OR of set-bit positions; exact for one-hot or zero input
   function automatic int oh2idx(input logic [31:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if (oh[i]) r = r | i;
      return r;
   endfunction

endpackage

// File: rtl/rr_grant_fsm_if.sv
// Request/grant bundle between clients and the grant sequencer.
// master is the sequencer side, slave is the client side.
interface rr_grant_fsm_if
   import rr_arb_pkg::*;
#(
   parameter int WIDTH = 4
);
   localparam int IW = clog2(WIDTH);

   logic [WIDTH-1:0] req;
   logic             ack;
   logic [WIDTH-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic             grant_valid;
   logic             grant_load;
   logic             timeout;

   modport master (
      input  req, ack,
      output grant, grant_idx, grant_valid,
      output grant_load, timeout
   );

   modport slave (
      output req, ack,
      input  grant, grant_idx, grant_valid,
      input  grant_load, timeout
   );

endinterface

// File: rtl/rr_priority_mask.sv
// Circular first-set-bit select starting at one-hot ptr.
// Masked copy in the low half wins over the unmasked wrap half.
module rr_priority_mask #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] ptr,
   output logic [WIDTH-1:0] sel
);
   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] low;

   assign dbl = {req, req & ~(ptr - WIDTH'(1))};
   assign low = dbl & (~dbl + (2*WIDTH)'(1));
   assign sel = low[WIDTH-1:0] | low[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin grant sequencer: IDLE/BUSY FSM, priority pointer, outputs.
// Define RR_TIMEOUT_EN to build the forced-release timeout counter.
module rr_grant_fsm
   import rr_arb_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 16
) (
   input logic         clk,
   input logic         rst,
   rr_grant_fsm_if.master bus
);
   localparam int IW = clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] ptr;
   logic [WIDTH-1:0] grant;
   logic [IW-1:0]    idx;
   logic             valid;
   logic             load;
   logic             tout;

   logic [WIDTH-1:0] rot;
   logic [WIDTH-1:0] sel_idle;
   logic [WIDTH-1:0] sel_rel;
   logic             expire;
   logic             rel;

   // pointer after release: one past the served requester
   assign rot = {grant[WIDTH-2:0], grant[WIDTH-1]};

   rr_priority_mask #(.WIDTH(WIDTH)) u_sel_idle (
      .req (bus.req),
      .ptr (ptr),
      .sel (sel_idle)
   );

   rr_priority_mask #(.WIDTH(WIDTH)) u_sel_rel (
      .req (bus.req),
      .ptr (rot),
      .sel (sel_rel)
   );

`ifdef RR_TIMEOUT_EN
   localparam int CW = clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expire = (state == BUSY) && !bus.ack
                && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (state == IDLE || rel)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end
`else
   assign expire = 1'b0;
`endif

   assign rel = (state == BUSY) && (bus.ack || expire);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= WIDTH'(1);
         grant <= '0;
         idx   <= '0;
         valid <= 1'b0;
         load  <= 1'b0;
         tout  <= 1'b0;
      end else begin
         load <= 1'b0;
         tout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|sel_idle) begin
                  state <= BUSY;
                  grant <= sel_idle;
                  idx   <= IW'(oh2idx(32'(sel_idle)));
                  valid <= 1'b1;
                  load  <= 1'b1;
               end
            end
            BUSY: begin
               if (rel) begin
                  ptr  <= rot;
                  tout <= expire;
                  if (|sel_rel) begin
                     grant <= sel_rel;
                     idx   <= IW'(oh2idx(32'(sel_rel)));
                     load  <= 1'b1;
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                     idx   <= '0;
                     valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant       = grant;
   assign bus.grant_idx   = idx;
   assign bus.grant_valid = valid;
   assign bus.grant_load  = load;
   assign bus.timeout     = tout;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed plus random checks of rr_grant_fsm against a behavioural model.
// Timeout scenarios run only when RR_TIMEOUT_EN is defined.
module tb_rr_grant_fsm;
   localparam int W = 4;
   localparam int T = 16;
`ifdef RR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   rr_grant_fsm_if #(.WIDTH(W)) bus ();

   rr_grant_fsm #(.WIDTH(W), .TIMEOUT(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: pointer index, grant index, busy flag, age of grant
   int mp, mg, mcnt;
   bit mbusy, mload, mto;

   function automatic int pick(int p, logic [W-1:0] rq);
      for (int k = 0; k < W; k++)
         if (rq[(p + k) % W]) return (p + k) % W;
      return -1;
   endfunction

   task automatic model(logic r, logic [W-1:0] rq, logic a);
      int s;
      bit ex;
      if (r) begin
         mp = 0; mg = 0; mcnt = 0;
         mbusy = 0; mload = 0; mto = 0;
         return;
      end
      mload = 0;
      mto   = 0;
      if (!mbusy) begin
         s = pick(mp, rq);
         if (s >= 0) begin
            mg = s; mbusy = 1; mload = 1; mcnt = 0;
         end
      end else begin
         ex = TO_EN && !a && (mcnt == T - 1);
         if (a || ex) begin
            mp  = (mg + 1) % W;
            mto = ex;
            s   = pick(mp, rq);
            if (s >= 0) begin
               mg = s; mload = 1; mcnt = 0;
            end else begin
               mbusy = 0;
            end
         end else begin
            mcnt++;
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic step(logic r, logic [W-1:0] rq, logic a);
      @(negedge clk);
      rst     = r;
      bus.req = rq;
      bus.ack = a;
      @(posedge clk);
      model(r, rq, a);
      #1;
      chk("grant", 32'(bus.grant), mbusy ? (32'd1 << mg) : 32'd0);
      chk("grant_idx", 32'(bus.grant_idx), mbusy ? 32'(mg) : 32'd0);
      chk("grant_valid", 32'(bus.grant_valid), 32'(mbusy));
      chk("grant_load", 32'(bus.grant_load), 32'(mload));
      chk("timeout", 32'(bus.timeout), 32'(mto));
   endtask

   initial begin
      logic [W-1:0] rot_exp [4];
      int held;
      rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      bus.req = '0;
      bus.ack = 1'b0;
      model(1'b1, '0, 1'b0);

      // reset with all requesting
      step(1, 4'b1111, 0);
      step(1, 4'b1111, 0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      step(0, 4'b1111, 0);
      chk("first_grant", 32'(bus.grant), 32'd1);
      chk("first_load", 32'(bus.grant_load), 32'd1);

      // full rotation, one grant per cycle
      for (int i = 0; i < 4; i++) begin
         step(0, 4'b1111, 1);
         chk("rot_grant", 32'(bus.grant), 32'(rot_exp[i]));
         chk("rot_load", 32'(bus.grant_load), 32'd1);
      end

      // serve index 1, then wrap past 2,3 to 0
      step(0, 4'b1111, 1);
      chk("serve1", 32'(bus.grant), 32'd2);
      step(0, 4'b0011, 1);
      chk("wrap_grant", 32'(bus.grant), 32'd1);
      chk("wrap_idx", 32'(bus.grant_idx), 32'd0);

      // single requester held 3 cycles, then idle
      step(0, 4'b0100, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 4'b0100, 0);
         chk("hold3", 32'(bus.grant), 32'd4);
      end
      step(0, 4'b0000, 1);
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_valid", 32'(bus.grant_valid), 32'd0);
      step(0, 4'b0000, 1);
      chk("ack_idle", 32'(bus.grant_valid), 32'd0);

      // dropped req does not revoke
      step(0, 4'b1000, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 4'b0000, 0);
         chk("held_grant", 32'(bus.grant), 32'd8);
      end
      step(0, 4'b0000, 1);

`ifdef RR_TIMEOUT_EN
      step(0, 4'b0110, 0);
      held = 1;
      while (bus.grant == 4'b0010 && held < 40) begin
         step(0, 4'b0110, 0);
         if (bus.grant == 4'b0010) held++;
      end
      chk("to_len", 32'(held), 32'(T));
      chk("to_pulse", 32'(bus.timeout), 32'd1);
      chk("to_next", 32'(bus.grant), 32'd4);
      for (int i = 0; i < T - 1; i++)
         step(0, 4'b0110, 0);
      step(0, 4'b0110, 1);
      chk("ack_wins", 32'(bus.timeout), 32'd0);
      chk("ack_next", 32'(bus.grant), 32'd2);
`endif

      // reset mid-grant
      step(0, 4'b1111, 0);
      step(1, 4'b1111, 0);
      chk("midrst_grant", 32'(bus.grant), 32'd0);
      chk("midrst_load", 32'(bus.grant_load), 32'd0);
      step(0, 4'b1111, 0);
      chk("post_rst", 32'(bus.grant), 32'd1);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(63) == 0, W'($urandom),
              $urandom_range(3) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
